// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types for the PWM generator
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_period_cntr.sv
// rtl/pwm_period_cntr.sv - modulo-PERIOD tick counter with wrap strobe
module pwm_period_cntr #(
    parameter int PERIOD = 10,
    parameter int CW     = $clog2(PERIOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    // wrap is the period boundary: the advancing cycle that returns cnt to 0
    assign wrap = adv && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - PWM generator with shadowed duty and graceful stop
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int PERIOD = 10,
    parameter int DW     = $clog2(PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          tick,
    input  logic [DW-1:0] duty,
    input  logic          duty_vld,
    output logic          duty_rdy,
    output logic          pwm_out,
    output logic          period_done
);

    localparam int            CW       = $clog2(PERIOD);
    localparam logic [DW-1:0] PERIOD_D = DW'(PERIOD);

    pwm_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] cnt_ext;
    logic          wrap;
    logic          clr;
    logic          adv;
    logic          start;
    logic [DW-1:0] shadow;
    logic          shadow_full;
    logic [DW-1:0] duty_act;
    logic [DW-1:0] duty_clamped;
    logic          accept;
    logic          shadow_load;

    assign clr   = (state == ST_IDLE);
    assign adv   = tick && !clr;
    assign start = (state == ST_IDLE) && en;

    pwm_period_cntr #(
        .PERIOD (PERIOD),
        .CW     (CW)
    ) u_cntr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .adv   (adv),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = ST_RUN;
            ST_RUN:  if (!en) state_nxt = ST_STOP;
            ST_STOP: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end else if (wrap) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign duty_rdy     = !shadow_full;
    assign accept       = duty_vld && !shadow_full;
    assign duty_clamped = (duty > PERIOD_D) ? PERIOD_D : duty;
    // A full shadow cannot accept, so a duty taken on a boundary waits a period
    assign shadow_load  = shadow_full && (start || wrap);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shadow      <= '0;
            shadow_full <= 1'b0;
            duty_act    <= '0;
            period_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            period_done <= wrap;
            if (shadow_load) begin
                duty_act    <= shadow;
                shadow_full <= 1'b0;
            end else if (accept) begin
                shadow      <= duty_clamped;
                shadow_full <= 1'b1;
            end
        end
    end

    assign cnt_ext = DW'(cnt);
    assign pwm_out = (state != ST_IDLE) && (cnt_ext < duty_act);

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - self-checking bench for pwm_gen
module tb_pwm_gen;

    localparam int P  = 10;
    localparam int DW = $clog2(P + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          tick = 1'b0;
    logic [DW-1:0] duty = '0;
    logic          duty_vld = 1'b0;
    logic          duty_rdy;
    logic          pwm_out;
    logic          period_done;

    always #5 clk = ~clk;

    pwm_gen #(.PERIOD(P)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .tick        (tick),
        .duty        (duty),
        .duty_vld    (duty_vld),
        .duty_rdy    (duty_rdy),
        .pwm_out     (pwm_out),
        .period_done (period_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pos;

    typedef struct {
        int d;
        int div;
        int exp_high;
        int exp_done;
    } vec_t;
    vec_t vecs[7];

    // reference model state: mode 0=idle 1=run 2=stop, m_pos = ticks into period
    int m_mode, m_pos, m_act, m_sh;
    bit m_full, m_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_step();
        tick = 1'b1;
        step();
        pos = (pos + 1) % P;
    endtask

    task automatic advance_to(input int target);
        while (pos != target) run_step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        duty_vld = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic load_duty(input int d);
        duty = DW'(d);
        duty_vld = 1'b1;
        step();
        duty_vld = 1'b0;
    endtask

    task automatic check_wave(input string name, input int n, input int d, input bit fresh);
        logic [63:0] gp, gd, ep, ed;
        gp = '0; gd = '0; ep = '0; ed = '0;
        for (int i = 0; i < n; i++) begin
            run_step();
            gp[i] = pwm_out;
            gd[i] = period_done;
            ep[i] = (pos < d);
            ed[i] = (pos == 0) && !(fresh && i == 0);
        end
        chk({name, "_pwm"}, gp, ep);
        chk({name, "_done"}, gd, ed);
    endtask

    task automatic model_update();
        bit at_end;
        at_end = (m_mode != 0) && tick && (m_pos == P - 1);
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_act = 0; m_sh = 0; m_full = 0; m_done = 0;
        end else begin
            m_done = at_end;
            if (m_full && ((m_mode == 0 && en) || at_end)) begin
                m_act = m_sh;
                m_full = 0;
            end else if (duty_vld && !m_full) begin
                m_sh = (int'(duty) > P) ? P : int'(duty);
                m_full = 1;
            end
            m_pos = (m_mode == 0) ? 0 : (tick ? (m_pos + 1) % P : m_pos);
            if (en) m_mode = 1;
            else if (m_mode == 1) m_mode = 2;
            else if (m_mode == 2 && at_end) m_mode = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, ph, highs, dones;
        logic [63:0] gp, gd, ep, ed;

        vecs[0] = '{d: 3,  div: 1, exp_high: 3,  exp_done: 1};
        vecs[1] = '{d: 15, div: 1, exp_high: 10, exp_done: 1};
        vecs[2] = '{d: 0,  div: 1, exp_high: 0,  exp_done: 1};
        vecs[3] = '{d: 2,  div: 3, exp_high: 6,  exp_done: 1};
        vecs[4] = '{d: 10, div: 1, exp_high: 10, exp_done: 1};
        vecs[5] = '{d: 7,  div: 2, exp_high: 14, exp_done: 1};
        vecs[6] = '{d: 1,  div: 1, exp_high: 1,  exp_done: 1};

        do_reset();
        chk("reset_pwm", pwm_out, 0);
        chk("reset_done", period_done, 0);
        chk("reset_rdy", duty_rdy, 1);

        // steady-state duty and tick-rate table
        for (int k = 0; k < 7; k++) begin
            do_reset();
            load_duty(vecs[k].d);
            en = 1'b1;
            ph = 0;
            guard = 0;
            while (!period_done && guard < 400) begin
                tick = (ph == 0);
                ph = (ph + 1) % vecs[k].div;
                step();
                guard++;
            end
            chk($sformatf("v%0d_first_done", k), guard < 400, 1);
            highs = 0;
            dones = 0;
            for (int j = 0; j < P * vecs[k].div; j++) begin
                highs += int'(pwm_out);
                dones += int'(period_done);
                tick = (ph == 0);
                ph = (ph + 1) % vecs[k].div;
                step();
            end
            chk($sformatf("v%0d_high", k), highs, vecs[k].exp_high);
            chk($sformatf("v%0d_done", k), dones, vecs[k].exp_done);
        end

        // reset then handshake, then start with duty 3
        do_reset();
        chk("hs_rdy_idle", duty_rdy, 1);
        load_duty(3);
        chk("hs_rdy_full", duty_rdy, 0);
        en = 1'b1;
        pos = P - 1;
        check_wave("hs_duty3", 20, 3, 1);
        chk("hs_rdy_after", duty_rdy, 1);

        // mid-period update lands on the next boundary
        advance_to(1);
        duty = DW'(7);
        duty_vld = 1'b1;
        run_step();
        duty_vld = 1'b0;
        chk("upd_rdy_drop", duty_rdy, 0);
        chk("upd_pwm_still3", pwm_out, 1);
        check_wave("upd_cur", 7, 3, 0);
        check_wave("upd_next", 10, 7, 0);
        chk("upd_rdy_back", duty_rdy, 1);

        // graceful stop from cnt=4
        advance_to(4);
        en = 1'b0;
        gp = '0; gd = '0; ep = '0; ed = '0;
        for (int i = 0; i < 10; i++) begin
            run_step();
            gp[i] = pwm_out;
            gd[i] = period_done;
            ep[i] = (i < 5) && ((5 + i) < 7);
            ed[i] = (i == 5);
        end
        chk("stop_pwm", gp, ep);
        chk("stop_done", gd, ed);

        en = 1'b1;
        pos = P - 1;
        check_wave("restart", 10, 7, 1);
        advance_to(4);
        en = 1'b0;
        run_step();
        run_step();
        en = 1'b1;
        check_wave("reraise", 15, 7, 0);

        // reset mid-period with a pending shadow
        advance_to(3);
        duty = DW'(5);
        duty_vld = 1'b1;
        run_step();
        duty_vld = 1'b0;
        run_step();
        chk("rst_mid_full", duty_rdy, 0);
        rst_n = 1'b0;
        en = 1'b0;
        step();
        chk("rst_mid_pwm", pwm_out, 0);
        chk("rst_mid_done", period_done, 0);
        chk("rst_mid_rdy", duty_rdy, 1);
        rst_n = 1'b1;
        en = 1'b1;
        pos = P - 1;
        check_wave("rst_discard", 10, 0, 1);

        // randomized run against the reference model
        rst_n = 1'b0;
        en = 1'b0;
        duty_vld = 1'b0;
        model_update();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) en = ~en;
            tick = $urandom_range(0, 1);
            if (!(duty_vld && !duty_rdy)) begin
                duty_vld = ($urandom_range(0, 7) == 0);
                duty = DW'($urandom_range(0, 15));
            end
            model_update();
            step();
            chk($sformatf("rnd%0d_pwm", c), pwm_out, (m_mode != 0) && (m_pos < m_act));
            chk($sformatf("rnd%0d_done", c), period_done, m_done);
            chk($sformatf("rnd%0d_rdy", c), duty_rdy, !m_full);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 Parameter PERIOD, default 10: ticks per PWM period; legal range 2..2^16.
REQ-002 Parameter DW, default $clog2(PERIOD+1): duty field width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  run request, level-sensitive.
REQ-006 tick  input  1  count-advance strobe from the upstream prescaler; one-cycle pulse or held high.
REQ-007 duty  input  DW  requested high-time in ticks, 0..PERIOD.
REQ-008 duty_vld  input  1  duty is valid.
REQ-009 duty_rdy  output  1  shadow register empty; the module can accept duty.
REQ-010 pwm_out  output  1  PWM waveform.
REQ-011 period_done  output  1  one-cycle pulse at the end of each period.

Function
REQ-012 Internal period counter cnt shall be $clog2(PERIOD) bits, count 0..PERIOD-1, and advance only on cycles where tick=1 in RUN or STOP.
REQ-013 cnt shall wrap from PERIOD-1 to 0 on tick; this wrap cycle is the period boundary.
REQ-014 FSM states: IDLE, RUN, STOP.
  - IDLE->RUN when en=1.
  - RUN->STOP when en=0.
  - STOP->RUN when en=1, with cnt continuing and no gap.
  - STOP->IDLE at the period boundary.
REQ-015 In IDLE: cnt=0, pwm_out=0, period_done=0.
REQ-016 pwm_out shall be 1 iff state is RUN or STOP and cnt < duty_act. It shall be decoded from registers only, with no combinational path from any input.
REQ-017 Duty handshake:
  - Transfer occurs when duty_vld && duty_rdy.
  - shadow <= min(duty, PERIOD), and shadow_full <= 1.
  - duty_rdy = !shadow_full.
REQ-018 Shadow to active transfer: if shadow_full on the IDLE->RUN transition or at a period boundary, duty_act <= shadow and shadow_full <= 0. Otherwise duty_act holds.
REQ-019 A transfer accepted on a boundary cycle shall land in shadow and be applied at the next boundary, not the current one.
REQ-020 duty_act=0 gives constant low; duty_act=PERIOD gives constant high across boundaries.
REQ-021 period_done shall assert, registered, in the cycle after each boundary, in both RUN and STOP.
REQ-022 duty_vld held while duty_rdy=0 shall not change shadow; the requester must hold duty until the transfer.

Reset
REQ-023 When rst_n=0 at a posedge, the following values shall be set:
  - state=IDLE, cnt=0, duty_act=0, shadow=0, shadow_full=0.
  - Outputs: pwm_out=0, period_done=0, duty_rdy=1.
REQ-024 Reset mid-period shall abort immediately, with no period_done pulse and no shadow transfer.

Structure
REQ-025 The state enum type (IDLE/RUN/STOP) shall be declared in package pwm_pkg.
REQ-026 The period counter shall be a sub-module, pwm_period_cntr.
  - Inputs: clk, rst_n, clr, adv.
  - Outputs: cnt, wrap.
REQ-027 All other logic shall be in pwm_gen.

Verification
REQ-028 Reset then handshake: rst_n=0 for 2 cycles, duty=3 with vld, en=1, tick=1 continuously -> duty_rdy=1 out of reset; pwm_out high 3 cycles, low 7, repeating; period_done every 10 cycles.
REQ-029 Update at boundary: in RUN with duty 3, send duty=7 mid-period -> duty_rdy drops the next cycle; the current period stays at 3-high; the next period is 7-high; duty_rdy returns high after the boundary.
REQ-030 Clamp and extremes:
  - duty=15 -> duty_act=10, pwm_out constantly high.
  - duty=0 -> pwm_out constantly low.
  - period_done still pulses in both cases.
REQ-031 Graceful stop: drop en at cnt=4 -> the period completes to cnt=9, period_done pulses once, the state goes IDLE, and pwm_out=0 afterwards. Re-raising en during STOP -> the waveform continues uninterrupted.
REQ-032 Sparse tick: tick every 3rd cycle, duty=2 -> pwm_out high for 6 cycles out of each 30.
REQ-033 Reset mid-operation: assert rst_n=0 at cnt=5 with shadow_full=1 -> next cycle all reset values apply; the shadow is discarded and duty_rdy=1.
